// File: rtl/ask4_symbol_source.sv
// Pseudo-random 4-ASK symbol source for the pulse-shaping FIR: one zero-stuffed symbol per SPS
// clocks, plus impulse-train and zero modes. All outputs are registered.
module ask4_symbol_source #(
    parameter int                 SPS        = 4,
    parameter logic [14:0]        LFSR_SEED  = 15'h0001,
    parameter logic signed [17:0] AMP        = 18'sd21845,
    parameter logic signed [17:0] IMP_AMP    = 18'sd131071,
    parameter int                 IMP_PERIOD = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    output logic signed [17:0]      x_out,
    output logic                    sym_strobe,
    output logic [1:0]              sym_bits,
    output logic [$clog2(SPS)-1:0]  phase
);

    localparam int PW = $clog2(SPS);
    localparam int CW = $clog2(IMP_PERIOD);
    localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(IMP_PERIOD - 1);
    localparam logic signed [17:0] AMP3 = 18'(AMP * 18'sd3);

    if ((SPS < 2) || (SPS > 16) || ((SPS & (SPS - 1)) != 0)) begin : g_bad_sps
        $error("SPS must be a power of 2 in 2..16");
    end
    if (LFSR_SEED == 15'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end
    if ((32'(AMP) * 3) > 131071) begin : g_bad_amp
        $error("3*AMP overflows 1s17");
    end
    if (IMP_PERIOD < 8) begin : g_bad_period
        $error("IMP_PERIOD must be at least 8");
    end

    // x^15+x^14+1 Fibonacci step; an all-zero state reloads the seed so the source never stalls.
    function automatic logic [14:0] lfsr_next(input logic [14:0] s);
        if (s == 15'h0000) begin
            return LFSR_SEED;
        end else begin
            return {s[13:0], s[14] ^ s[13]};
        end
    endfunction

    // Gray-coded 4-ASK level map.
    function automatic logic signed [17:0] ask_level(input logic [1:0] b);
        case (b)
            2'b00:   return -AMP3;
            2'b01:   return -AMP;
            2'b11:   return AMP;
            2'b10:   return AMP3;
            default: return 18'sd0;
        endcase
    endfunction

    logic [PW-1:0]        phase_r,   phase_s;
    logic [14:0]          lfsr_r,    lfsr_s;
    logic [14:0]          lfsr_adv_s;
    logic [CW-1:0]        imp_cnt_r, imp_cnt_s;
    logic [1:0]           mode_q_r,  mode_q_s;
    logic signed [17:0]   x_r,       x_s;
    logic                 strobe_r,  strobe_s;
    logic [1:0]           bits_r,    bits_s;

    // Next-state: advance phase, and on a symbol boundary step the LFSR and emit a sample.
    always_comb begin
        phase_s    = phase_r;
        lfsr_s     = lfsr_r;
        imp_cnt_s  = imp_cnt_r;
        mode_q_s   = mode_q_r;
        bits_s     = bits_r;
        x_s        = 18'sd0;
        strobe_s   = 1'b0;
        lfsr_adv_s = lfsr_next(lfsr_r);
        if (enable) begin
            if (phase_r == PH_LAST) begin
                phase_s   = {PW{1'b0}};
                mode_q_s  = mode;
                lfsr_s    = lfsr_adv_s;
                bits_s    = lfsr_adv_s[1:0];
                strobe_s  = 1'b1;
                imp_cnt_s = (imp_cnt_r == CNT_LAST) ? {CW{1'b0}} : imp_cnt_r + CW'(1);
                // The impulse decision looks at the count before it advances.
                case (mode_q_s)
                    2'b00:   x_s = ask_level(lfsr_adv_s[1:0]);
                    2'b01:   x_s = (imp_cnt_r == {CW{1'b0}}) ? IMP_AMP : 18'sd0;
                    default: x_s = 18'sd0;
                endcase
            end else begin
                phase_s = phase_r + PW'(1);
            end
        end else begin
            phase_s = phase_r;
        end
    end

    // State and output registers; reset abandons any symbol in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r   <= PH_LAST;
            lfsr_r    <= LFSR_SEED;
            imp_cnt_r <= {CW{1'b0}};
            mode_q_r  <= 2'b00;
            x_r       <= 18'sd0;
            strobe_r  <= 1'b0;
            bits_r    <= 2'b00;
        end else begin
            phase_r   <= phase_s;
            lfsr_r    <= lfsr_s;
            imp_cnt_r <= imp_cnt_s;
            mode_q_r  <= mode_q_s;
            x_r       <= x_s;
            strobe_r  <= strobe_s;
            bits_r    <= bits_s;
        end
    end

    assign x_out      = x_r;
    assign sym_strobe = strobe_r;
    assign sym_bits   = bits_r;
    assign phase      = phase_r;

endmodule
